// File: rtl/mem_arbiter_if.sv
// Bundle of datapath-side request/response signals and memory-side port signals for mem_arbiter.
// The slave modport is the arbiter's view; master is the view of the datapath plus memory around it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              instMem_rd;
  logic [ADDR_W-1:0] instMem_addr;
  logic [DATA_W-1:0] instMem_data;
  logic              inst_ready;

  logic              dataMem_rd;
  logic              dataMem_wr;
  logic [ADDR_W-1:0] dataMem_addr;
  logic [DATA_W-1:0] dataMem_wdata;
  logic [DATA_W-1:0] dataMem_rdata;
  logic              data_ready;

  logic              bus_err;
  logic              stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  instMem_rd, instMem_addr, dataMem_rd, dataMem_wr, dataMem_addr, dataMem_wdata,
           mem_rdata, mem_ack,
    output instMem_data, inst_ready, dataMem_rdata, data_ready, bus_err, stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output instMem_rd, instMem_addr, dataMem_rd, dataMem_wr, dataMem_addr, dataMem_wdata,
           mem_rdata, mem_ack,
    input  instMem_data, inst_ready, dataMem_rdata, data_ready, bus_err, stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and data accesses onto one variable-latency memory port,
// with read-data holding, datapath stall and an access watchdog. MEM_ARB_FAIR_EN selects round-robin.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;
  typedef enum logic {SIDE_INST = 1'b0, SIDE_DATA = 1'b1} side_e;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  side_e             gnt_q, gnt_d;
  side_e             pick;
  logic              err_q, err_d;
  logic [7:0]        wdog_q, wdog_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] inst_data_q, inst_data_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              inst_pend, data_pend;
  logic              inst_ready, data_ready;

  assign inst_pend = bus.instMem_rd;
  assign data_pend = bus.dataMem_rd | bus.dataMem_wr;

`ifdef MEM_ARB_FAIR_EN
  side_e last_q, last_d;

  // On contention the side not served last wins; a lone requester always wins.
  always_comb begin
    if (inst_pend && data_pend) begin
      pick = (last_q == SIDE_DATA) ? SIDE_INST : SIDE_DATA;
    end else if (data_pend) begin
      pick = SIDE_DATA;
    end else begin
      pick = SIDE_INST;
    end
  end

  assign last_d = (state_q == ST_IDLE && (inst_pend || data_pend)) ? pick : last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= SIDE_DATA;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    pick = data_pend ? SIDE_DATA : SIDE_INST;
  end
`endif

  always_comb begin
    // NOTE: every next-state variable takes its current value first, so no path leaves one unassigned (no latches).
    state_d      = state_q;
    gnt_d        = gnt_q;
    err_d        = err_q;
    wdog_d       = wdog_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_data_d  = inst_data_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (inst_pend || data_pend) begin
          gnt_d     = pick;
          err_d     = 1'b0;
          wdog_d    = 8'd0;
          mem_req_d = 1'b1;
          state_d   = ST_WAIT;
          if (pick == SIDE_DATA) begin
            mem_we_d    = bus.dataMem_wr;
            mem_addr_d  = bus.dataMem_addr;
            mem_wdata_d = bus.dataMem_wdata;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = bus.instMem_addr;
          end
        end
      end

      ST_WAIT: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
          if (!mem_we_q) begin
            if (gnt_q == SIDE_DATA) data_rdata_d = bus.mem_rdata;
            else                    inst_data_d  = bus.mem_rdata;
          end
        end else if (wdog_q == WDOG_LAST) begin
          // An abandoned read returns zero so stale data cannot masquerade as a result.
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_DONE;
          if (!mem_we_q) begin
            if (gnt_q == SIDE_DATA) data_rdata_d = '0;
            else                    inst_data_d  = '0;
          end
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= SIDE_DATA;
      err_q        <= 1'b0;
      wdog_q       <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_data_q  <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      err_q        <= err_d;
      wdog_q       <= wdog_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_data_q  <= inst_data_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign inst_ready = (state_q == ST_DONE) && (gnt_q == SIDE_INST);
  assign data_ready = (state_q == ST_DONE) && (gnt_q == SIDE_DATA);

  assign bus.inst_ready    = inst_ready;
  assign bus.data_ready    = data_ready;
  assign bus.bus_err       = (state_q == ST_DONE) && err_q;
  assign bus.instMem_data  = inst_data_q;
  assign bus.dataMem_rdata = data_rdata_q;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;

  // Combinational so the datapath is released in the very cycle its ready pulse arrives.
  assign bus.stall = (inst_pend & ~inst_ready) | (data_pend & ~data_ready);

endmodule
